// File: rtl/ovl_cycle_seq_gen_pkg.sv
//------------------------------------------------------------------------------
// ovl_cycle_seq_gen_pkg : shared types and constants for ovl_cycle_sequence_gen
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ovl_cycle_seq_gen_pkg;

    localparam int OVL_TRIGGER_ON_MOST_PIPE    = 0;
    localparam int OVL_TRIGGER_ON_FIRST_PIPE   = 1;
    localparam int OVL_TRIGGER_ON_FIRST_NOPIPE = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_DRAIN  = 2'd2
    } gen_state_e;

    function automatic logic is_nopipe(input int mode);
        return (mode == OVL_TRIGGER_ON_FIRST_NOPIPE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ovl_cycle_seq_shifter.sv
//------------------------------------------------------------------------------
// ovl_cycle_seq_shifter : token/last/poison shift chain with event/done decode
// Build option: OVL_CYCLE_SEQ_GEN_INJECT_EN adds the poison chain.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ovl_cycle_seq_shifter #(
    parameter int NUM_CKS = 3,
    parameter int STEP_W  = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               launch,
    input  logic               launch_last,
`ifdef OVL_CYCLE_SEQ_GEN_INJECT_EN
    input  logic               launch_poison,
    input  logic [STEP_W-1:0]  inject_step,
`endif
    output logic               tok_busy,
    output logic [NUM_CKS-1:0] event_sequence,
    output logic               done
);

    logic [NUM_CKS-1:0] tok_q,  tok_d;
    logic [NUM_CKS-1:0] last_q, last_d;

    // A new token enters at the first-event end and walks toward bit 0.
    always_comb begin
        tok_d  = {launch,      tok_q[NUM_CKS-1:1]};
        last_d = {launch_last, last_q[NUM_CKS-1:1]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tok_q  <= '0;
            last_q <= '0;
        end else begin
            tok_q  <= tok_d;
            last_q <= last_d;
        end
    end

`ifdef OVL_CYCLE_SEQ_GEN_INJECT_EN
    logic [NUM_CKS-1:0] poison_q, poison_d;
    logic [NUM_CKS-1:0] step_sel;
    logic [31:0]        step_ext;

    always_comb begin
        poison_d = {launch_poison, poison_q[NUM_CKS-1:1]};
        step_ext = 32'(inject_step);
        for (int k = 0; k < NUM_CKS; k++) begin
            step_sel[k] = (step_ext == 32'(k));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poison_q <= '0;
        end else begin
            poison_q <= poison_d;
        end
    end

    assign event_sequence = tok_q & ~(poison_q & step_sel);
`else
    assign event_sequence = tok_q;
`endif

    // done follows the token, not the (possibly suppressed) event bit.
    assign done     = tok_q[0] & last_q[0];
    assign tok_busy = |tok_q;

endmodule

`default_nettype wire

// File: rtl/ovl_cycle_sequence_gen.sv
//------------------------------------------------------------------------------
// ovl_cycle_sequence_gen : burst stimulus generator for the OVL cycle-sequence
// checker. Build option: OVL_CYCLE_SEQ_GEN_INJECT_EN enables fault injection.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ovl_cycle_sequence_gen
    import ovl_cycle_seq_gen_pkg::*;
#(
    parameter int NUM_CKS             = 3,
    parameter int NECESSARY_CONDITION = 0,
    parameter int CNT_W               = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [7:0]                  count,
    input  logic                        inject,
    input  logic [$clog2(NUM_CKS)-1:0]  inject_step,
    output logic                        ready,
    output logic                        busy,
    output logic [NUM_CKS-1:0]          event_sequence,
    output logic                        done,
    output logic [CNT_W-1:0]            launch_cnt
);

    localparam int   STEP_W = $clog2(NUM_CKS);
    localparam logic NOPIPE = is_nopipe(NECESSARY_CONDITION);

    gen_state_e       state_q, state_d;
    logic [7:0]       rem_q, rem_d;
    logic [CNT_W-1:0] launch_cnt_q, launch_cnt_d;
    logic             launch;
    logic             launch_last;
    logic             tok_busy;
    logic             seq_done;

`ifdef OVL_CYCLE_SEQ_GEN_INJECT_EN
    logic              inject_q, inject_d;
    logic [STEP_W-1:0] inject_step_q, inject_step_d;
`endif

    // Non-overlapping mode holds off until the previous token has left the chain.
    assign launch      = (state_q == ST_LAUNCH) && (NOPIPE ? !tok_busy : 1'b1);
    assign launch_last = launch && (rem_q == 8'd1);

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        launch_cnt_d = launch_cnt_q;
`ifdef OVL_CYCLE_SEQ_GEN_INJECT_EN
        inject_d      = inject_q;
        inject_step_d = inject_step_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LAUNCH;
                    rem_d   = (count == 8'd0) ? 8'd1 : count;
`ifdef OVL_CYCLE_SEQ_GEN_INJECT_EN
                    inject_d      = inject;
                    inject_step_d = inject_step;
`endif
                end
            end
            ST_LAUNCH: begin
                if (launch) begin
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (seq_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (launch && (launch_cnt_q != {CNT_W{1'b1}})) begin
            launch_cnt_d = launch_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rem_q        <= 8'd0;
            launch_cnt_q <= '0;
`ifdef OVL_CYCLE_SEQ_GEN_INJECT_EN
            inject_q      <= 1'b0;
            inject_step_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            launch_cnt_q <= launch_cnt_d;
`ifdef OVL_CYCLE_SEQ_GEN_INJECT_EN
            inject_q      <= inject_d;
            inject_step_q <= inject_step_d;
`endif
        end
    end

    ovl_cycle_seq_shifter #(
        .NUM_CKS (NUM_CKS),
        .STEP_W  (STEP_W)
    ) u_shifter (
        .clk            (clk),
        .reset_n        (reset_n),
        .launch         (launch),
        .launch_last    (launch_last),
`ifdef OVL_CYCLE_SEQ_GEN_INJECT_EN
        .launch_poison  (launch && inject_q),
        .inject_step    (inject_step_q),
`endif
        .tok_busy       (tok_busy),
        .event_sequence (event_sequence),
        .done           (seq_done)
    );

    assign ready      = (state_q == ST_IDLE);
    assign busy       = !ready;
    assign done       = seq_done;
    assign launch_cnt = launch_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ovl_cycle_sequence_gen.sv
//------------------------------------------------------------------------------
// tb_ovl_cycle_sequence_gen : directed bench for ovl_cycle_sequence_gen
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ovl_cycle_sequence_gen;

    logic       clk;
    logic       reset_n;
    logic       start_p;
    logic       start_n;
    logic [7:0] count;
    logic       inject;
    logic [1:0] inject_step;

    logic        ready_p, busy_p, done_p;
    logic [2:0]  ev_p;
    logic [15:0] cnt_p;

    logic        ready_n, busy_n, done_n;
    logic [2:0]  ev_n;
    logic [2:0]  cnt_n;

    int checks;
    int failures;

    ovl_cycle_sequence_gen #(
        .NUM_CKS             (3),
        .NECESSARY_CONDITION (0),
        .CNT_W               (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start_p),
        .count          (count),
        .inject         (inject),
        .inject_step    (inject_step),
        .ready          (ready_p),
        .busy           (busy_p),
        .event_sequence (ev_p),
        .done           (done_p),
        .launch_cnt     (cnt_p)
    );

    ovl_cycle_sequence_gen #(
        .NUM_CKS             (3),
        .NECESSARY_CONDITION (2),
        .CNT_W               (3)
    ) dut_np (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start_n),
        .count          (count),
        .inject         (inject),
        .inject_step    (inject_step),
        .ready          (ready_n),
        .busy           (busy_n),
        .event_sequence (ev_n),
        .done           (done_n),
        .launch_cnt     (cnt_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        start_p     = 1'b0;
        start_n     = 1'b0;
        count       = 8'd0;
        inject      = 1'b0;
        inject_step = 2'd0;
        reset_n     = 1'b0;
        tick();
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    // Leaves the bench in cycle T+1 where T is the accepting cycle.
    task automatic accept_p(input logic [7:0] c, input logic inj, input logic [1:0] stp);
        count = c; inject = inj; inject_step = stp;
        start_p = 1'b1;
        tick();
        start_p = 1'b0;
    endtask

    task automatic accept_n(input logic [7:0] c);
        count = c; inject = 1'b0; inject_step = 2'd0;
        start_n = 1'b1;
        tick();
        start_n = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 6;
        if (ready_p !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_p); end
        if (busy_p !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_p); end
        if (ev_p !== 3'b000) begin failures++; $display("FAIL reset_ev got=%b exp=000", ev_p); end
        if (done_p !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_p); end
        if (cnt_p !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt_p); end
        if (ready_n !== 1'b1 || ev_n !== 3'b000 || cnt_n !== 3'd0) begin
            failures++;
            $display("FAIL reset_np got ready=%b ev=%b cnt=%0d exp ready=1 ev=000 cnt=0", ready_n, ev_n, cnt_n);
        end
    endtask

    task automatic test_single(input logic [7:0] c, input string tag);
        logic [2:0] exp_ev [4] = '{3'b100, 3'b010, 3'b001, 3'b000};
        logic       exp_dn [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_rd [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        accept_p(c, 1'b0, 2'd0);
        checks++;
        if (busy_p !== 1'b1) begin failures++; $display("FAIL %s_busy_t1 got=%b exp=1", tag, busy_p); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ev_p !== exp_ev[i] || done_p !== exp_dn[i] || ready_p !== exp_rd[i]) begin
                failures++;
                $display("FAIL %s_step%0d got ev=%b done=%b ready=%b exp ev=%b done=%b ready=%b",
                         tag, i + 2, ev_p, done_p, ready_p, exp_ev[i], exp_dn[i], exp_rd[i]);
            end
        end
        checks++;
        if (cnt_p !== 16'd1) begin failures++; $display("FAIL %s_cnt got=%0d exp=1", tag, cnt_p); end
    endtask

    task automatic test_pipe();
        logic [2:0] exp_ev [6] = '{3'b100, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000};
        logic       exp_dn [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_rd [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        accept_p(8'd3, 1'b0, 2'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (ev_p !== exp_ev[i] || done_p !== exp_dn[i] || ready_p !== exp_rd[i]) begin
                failures++;
                $display("FAIL pipe_step%0d got ev=%b done=%b ready=%b exp ev=%b done=%b ready=%b",
                         i + 2, ev_p, done_p, ready_p, exp_ev[i], exp_dn[i], exp_rd[i]);
            end
        end
        checks++;
        if (cnt_p !== 16'd3) begin failures++; $display("FAIL pipe_cnt got=%0d exp=3", cnt_p); end
    endtask

    task automatic test_nopipe();
        logic [2:0] exp_ev [8] = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000};
        logic       exp_dn [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_rd [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        accept_n(8'd2);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (ev_n !== exp_ev[i] || done_n !== exp_dn[i] || ready_n !== exp_rd[i]) begin
                failures++;
                $display("FAIL nopipe_step%0d got ev=%b done=%b ready=%b exp ev=%b done=%b ready=%b",
                         i + 2, ev_n, done_n, ready_n, exp_ev[i], exp_dn[i], exp_rd[i]);
            end
        end
        checks++;
        if (cnt_n !== 3'd2) begin failures++; $display("FAIL nopipe_cnt got=%0d exp=2", cnt_n); end
    endtask

    task automatic test_inject();
`ifdef OVL_CYCLE_SEQ_GEN_INJECT_EN
        logic [2:0] exp_ev [3][3] = '{'{3'b100, 3'b000, 3'b001},
                                      '{3'b100, 3'b010, 3'b000},
                                      '{3'b100, 3'b010, 3'b001}};
`else
        logic [2:0] exp_ev [3][3] = '{'{3'b100, 3'b010, 3'b001},
                                      '{3'b100, 3'b010, 3'b001},
                                      '{3'b100, 3'b010, 3'b001}};
`endif
        logic [1:0] steps [3] = '{2'd1, 2'd0, 2'd3};
        logic       exp_dn [3] = '{1'b0, 1'b0, 1'b1};
        apply_reset();
        for (int b = 0; b < 3; b++) begin
            accept_p(8'd1, 1'b1, steps[b]);
            for (int i = 0; i < 3; i++) begin
                tick();
                checks++;
                if (ev_p !== exp_ev[b][i] || done_p !== exp_dn[i]) begin
                    failures++;
                    $display("FAIL inject_b%0d_step%0d got ev=%b done=%b exp ev=%b done=%b",
                             b, i + 2, ev_p, done_p, exp_ev[b][i], exp_dn[i]);
                end
            end
            tick();
        end
        // Injection is per burst: a clean burst right after must be untouched.
        accept_p(8'd1, 1'b0, 2'd1);
        tick();
        tick();
        checks++;
        if (ev_p !== 3'b010) begin failures++; $display("FAIL inject_clear got=%b exp=010", ev_p); end
        tick();
        tick();
    endtask

    task automatic test_ignore_start();
        apply_reset();
        accept_p(8'd1, 1'b0, 2'd0);
        start_p = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 2) start_p = 1'b0;
        end
        checks += 2;
        if (ready_p !== 1'b1 || ev_p !== 3'b000) begin
            failures++;
            $display("FAIL ignore_idle got ready=%b ev=%b exp ready=1 ev=000", ready_p, ev_p);
        end
        if (cnt_p !== 16'd1) begin failures++; $display("FAIL ignore_cnt got=%0d exp=1", cnt_p); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        accept_p(8'd3, 1'b0, 2'd0);
        start_p = 1'b1;
        tick();
        tick();
        checks++;
        if (ev_p !== 3'b110) begin failures++; $display("FAIL rmid_pre got=%b exp=110", ev_p); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (ev_p !== 3'b000 || done_p !== 1'b0 || ready_p !== 1'b1 || busy_p !== 1'b0 || cnt_p !== 16'd0) begin
            failures++;
            $display("FAIL rmid_async got ev=%b done=%b ready=%b busy=%b cnt=%0d exp ev=000 done=0 ready=1 busy=0 cnt=0",
                     ev_p, done_p, ready_p, busy_p, cnt_p);
        end
        start_p = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (ev_p !== 3'b000 || ready_p !== 1'b1 || cnt_p !== 16'd0) begin
                failures++;
                $display("FAIL rmid_after%0d got ev=%b ready=%b cnt=%0d exp ev=000 ready=1 cnt=0",
                         i, ev_p, ready_p, cnt_p);
            end
        end
    endtask

    task automatic test_saturate();
        int ticks = 0;
        int dones = 0;
        apply_reset();
        accept_n(8'd13);
        while (ready_n !== 1'b1 && ticks < 200) begin
            tick();
            ticks++;
            if (done_n === 1'b1) dones++;
        end
        checks += 3;
        if (ticks != 52) begin failures++; $display("FAIL sat_duration got=%0d exp=52", ticks); end
        if (dones != 1) begin failures++; $display("FAIL sat_done_pulses got=%0d exp=1", dones); end
        if (cnt_n !== 3'd7) begin failures++; $display("FAIL sat_cnt got=%0d exp=7", cnt_n); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b1;
        start_p  = 1'b0;
        start_n  = 1'b0;
        count    = 8'd0;
        inject   = 1'b0;
        inject_step = 2'd0;
        test_reset();
        test_single(8'd1, "single");
        test_pipe();
        test_nopipe();
        test_inject();
        test_ignore_start();
        test_reset_mid();
        test_single(8'd0, "count0");
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
